// File: rtl/bus_pkg.sv
// Shared constants and types for the CPU memory-bus controller and its address decoder.
package bus_pkg;

    localparam logic [15:0] BUS_VGA_BASE    = 16'h1000;
    localparam logic [15:0] BUS_SDRAM_BASE  = 16'h4C00;
    localparam int          BUS_TIMEOUT_CYC = 64;
    localparam logic [15:0] BUS_TIMEOUT_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        RG_IO    = 2'd0,
        RG_UNMAP = 2'd1,
        RG_VGA   = 2'd2,
        RG_SDRAM = 2'd3
    } region_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SD_REQ  = 2'd1,
        SD_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/bus_decode.sv
// Combinational CPU address decode: region classification plus VGA and SDRAM offsets.
import bus_pkg::*;

module bus_decode #(
    parameter logic [15:0] VGA_BASE   = BUS_VGA_BASE,
    parameter logic [15:0] SDRAM_BASE = BUS_SDRAM_BASE
) (
    input  logic [15:0] addr,
    output region_t     region,
    output logic [15:0] vga_off,
    output logic [15:0] sd_off
);

    always_comb begin
        region = RG_SDRAM;
        if (addr == 16'h0000) begin
            region = RG_IO;
        end else if (addr < VGA_BASE) begin
            region = RG_UNMAP;
        end else if (addr < SDRAM_BASE) begin
            region = RG_VGA;
        end
    end

    // Offsets are only consumed when the region matches, so wrap-around never escapes.
    assign vga_off = addr - VGA_BASE;
    assign sd_off  = addr - SDRAM_BASE;

endmodule

// File: rtl/bus_ctrl.sv
// Registered CPU memory-bus controller: IO/VGA/SDRAM decode, SDRAM handshake, ready pulse.
// Optional SDRAM wait timeout with sticky bus_err is enabled by defining BUS_TIMEOUT_EN.
import bus_pkg::*;

module bus_ctrl #(
    parameter logic [15:0] VGA_BASE   = BUS_VGA_BASE,
    parameter logic [15:0] SDRAM_BASE = BUS_SDRAM_BASE
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = BUS_TIMEOUT_CYC
`endif
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [15:0] addr_bus,
    input  logic [15:0] ram_in,
    input  logic        ram_read,
    input  logic        ram_write,
    output logic [15:0] ram_out,
    output logic        ram_busy,
    output logic        ram_ready,
    input  logic [7:0]  btn_in,
    output logic [15:0] vga_addr,
    output logic [15:0] vga_data,
    output logic        vga_write,
    output logic [23:0] sd_addr,
    output logic [15:0] sd_wdata,
    output logic        sd_read,
    output logic        sd_write,
    input  logic        sd_busy,
    input  logic        sd_ready,
    input  logic [15:0] sd_rdata,
    output logic        bus_err
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_SD_REQ  = SD_REQ;
    localparam logic [1:0] S_SD_WAIT = SD_WAIT;
    localparam logic [1:0] S_DONE    = DONE;

    logic [1:0]  state_reg;
    logic [15:0] ram_out_reg;
    logic        ram_busy_reg;
    logic        ram_ready_reg;
    logic [15:0] vga_addr_reg;
    logic [15:0] vga_data_reg;
    logic        vga_write_reg;
    logic [23:0] sd_addr_reg;
    logic [15:0] sd_wdata_reg;
    logic        sd_read_reg;
    logic        sd_write_reg;

    region_t     region;
    logic [15:0] vga_off;
    logic [15:0] sd_off;
    logic        req_any;
    logic        req_is_write;
    logic        in_sd_phase;
    logic        tmo_hit;

    bus_decode #(
        .VGA_BASE   (VGA_BASE),
        .SDRAM_BASE (SDRAM_BASE)
    ) u_decode (
        .addr    (addr_bus),
        .region  (region),
        .vga_off (vga_off),
        .sd_off  (sd_off)
    );

    assign req_any      = ram_read | ram_write;
    assign req_is_write = ram_write;
    assign in_sd_phase  = (state_reg == S_SD_REQ) || (state_reg == S_SD_WAIT);

`ifdef BUS_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             bus_err_reg;

    // Counts cycles spent waiting on the SDRAM; fires on the last permitted cycle.
    assign tmo_hit = in_sd_phase && !sd_ready && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            tmo_cnt_reg <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            if (!in_sd_phase || sd_ready || tmo_hit) begin
                tmo_cnt_reg <= '0;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
            if (tmo_hit) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    assign bus_err = bus_err_reg;
`else
    assign tmo_hit = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            state_reg     <= S_IDLE;
            ram_out_reg   <= '0;
            ram_busy_reg  <= 1'b0;
            ram_ready_reg <= 1'b0;
            vga_addr_reg  <= '0;
            vga_data_reg  <= '0;
            vga_write_reg <= 1'b0;
            sd_addr_reg   <= '0;
            sd_wdata_reg  <= '0;
            sd_read_reg   <= 1'b0;
            sd_write_reg  <= 1'b0;
        end else begin
            // Strobes default low; only the owning state raises them for one cycle.
            vga_write_reg <= 1'b0;
            ram_ready_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (req_any) begin
                        case (region)
                            RG_IO: begin
                                if (!req_is_write) begin
                                    ram_out_reg <= {8'h00, btn_in};
                                end
                                state_reg <= S_DONE;
                            end
                            RG_UNMAP: begin
                                ram_out_reg <= '0;
                                state_reg   <= S_DONE;
                            end
                            RG_VGA: begin
                                if (req_is_write) begin
                                    vga_addr_reg  <= vga_off;
                                    vga_data_reg  <= ram_in;
                                    vga_write_reg <= 1'b1;
                                end else begin
                                    ram_out_reg <= '0;
                                end
                                state_reg <= S_DONE;
                            end
                            default: begin
                                sd_addr_reg  <= {8'h00, sd_off};
                                sd_wdata_reg <= ram_in;
                                sd_read_reg  <= !req_is_write;
                                sd_write_reg <= req_is_write;
                                ram_busy_reg <= 1'b1;
                                state_reg    <= S_SD_REQ;
                            end
                        endcase
                    end
                end

                S_SD_REQ, S_SD_WAIT: begin
                    if (sd_ready) begin
                        ram_out_reg  <= sd_rdata;
                        sd_read_reg  <= 1'b0;
                        sd_write_reg <= 1'b0;
                        ram_busy_reg <= 1'b0;
                        state_reg    <= S_DONE;
                    end else if (tmo_hit) begin
                        ram_out_reg  <= BUS_TIMEOUT_DATA;
                        sd_read_reg  <= 1'b0;
                        sd_write_reg <= 1'b0;
                        ram_busy_reg <= 1'b0;
                        state_reg    <= S_DONE;
                    end else if (state_reg == S_SD_REQ && sd_busy) begin
                        state_reg <= S_SD_WAIT;
                    end
                end

                default: begin
                    ram_busy_reg  <= 1'b0;
                    ram_ready_reg <= 1'b1;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_out   = ram_out_reg;
    assign ram_busy  = ram_busy_reg;
    assign ram_ready = ram_ready_reg;
    assign vga_addr  = vga_addr_reg;
    assign vga_data  = vga_data_reg;
    assign vga_write = vga_write_reg;
    assign sd_addr   = sd_addr_reg;
    assign sd_wdata  = sd_wdata_reg;
    assign sd_read   = sd_read_reg;
    assign sd_write  = sd_write_reg;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed self-checking bench for bus_ctrl; outputs sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_bus_ctrl;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic [15:0] addr_bus;
    logic [15:0] ram_in;
    logic        ram_read;
    logic        ram_write;
    logic [15:0] ram_out;
    logic        ram_busy;
    logic        ram_ready;
    logic [7:0]  btn_in;
    logic [15:0] vga_addr;
    logic [15:0] vga_data;
    logic        vga_write;
    logic [23:0] sd_addr;
    logic [15:0] sd_wdata;
    logic        sd_read;
    logic        sd_write;
    logic        sd_busy;
    logic        sd_ready;
    logic [15:0] sd_rdata;
    logic        bus_err;

    int vectors = 0;
    int miscompares = 0;
    int ready_pulses;
    int waited;

    always #5 cpu_clk = ~cpu_clk;

    bus_ctrl dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .addr_bus  (addr_bus),
        .ram_in    (ram_in),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_out   (ram_out),
        .ram_busy  (ram_busy),
        .ram_ready (ram_ready),
        .btn_in    (btn_in),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .vga_write (vga_write),
        .sd_addr   (sd_addr),
        .sd_wdata  (sd_wdata),
        .sd_read   (sd_read),
        .sd_write  (sd_write),
        .sd_busy   (sd_busy),
        .sd_ready  (sd_ready),
        .sd_rdata  (sd_rdata),
        .bus_err   (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    task automatic show(input string what);
        $display("[%0t] %s: ram_out=%h busy=%b ready=%b sd_rd=%b sd_wr=%b vga_wr=%b",
                 $time, what, ram_out, ram_busy, ram_ready, sd_read, sd_write, vga_write);
    endtask

    initial begin
        cpu_rst_n = 1'b0;
        addr_bus  = 16'h0000;
        ram_in    = 16'h0000;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        btn_in    = 8'h00;
        sd_busy   = 1'b0;
        sd_ready  = 1'b0;
        sd_rdata  = 16'h0000;

        // Reset state
        tick();
        tick();
        check("rst_ram_out", 32'(ram_out), 32'h0);
        check("rst_busy", 32'(ram_busy), 32'h0);
        check("rst_ready", 32'(ram_ready), 32'h0);
        check("rst_sd_rw", 32'({sd_read, sd_write}), 32'h0);
        check("rst_vga_write", 32'(vga_write), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        show("reset");
        cpu_rst_n = 1'b1;
        tick();

        // IO read of the button register
        addr_bus = 16'h0000; btn_in = 8'hA5; ram_read = 1'b1;
        tick();
        check("io_ready_e1", 32'(ram_ready), 32'h0);
        check("io_ram_out", 32'(ram_out), 32'h00A5);
        tick();
        check("io_ready_e2", 32'(ram_ready), 32'h1);
        check("io_no_side", 32'({sd_read, sd_write, vga_write, ram_busy}), 32'h0);
        ram_read = 1'b0;
        show("io read");
        tick();
        check("io_ready_drop", 32'(ram_ready), 32'h0);

        // VGA write
        addr_bus = 16'h1010; ram_in = 16'h1234; ram_write = 1'b1;
        tick();
        check("vga_write_pulse", 32'(vga_write), 32'h1);
        check("vga_addr", 32'(vga_addr), 32'h0010);
        check("vga_data", 32'(vga_data), 32'h1234);
        check("vga_ready_e1", 32'(ram_ready), 32'h0);
        ram_write = 1'b0;
        tick();
        check("vga_write_end", 32'(vga_write), 32'h0);
        check("vga_ready_e2", 32'(ram_ready), 32'h1);
        show("vga write");
        tick();

        // VGA upper boundary write
        addr_bus = 16'h4BFF; ram_in = 16'h5A5A; ram_write = 1'b1;
        tick();
        check("vga_hi_write", 32'({vga_write, sd_write}), 32'h2);
        check("vga_hi_addr", 32'(vga_addr), 32'h3BFF);
        ram_write = 1'b0;
        tick();
        show("vga boundary write");
        tick();

        // SDRAM read with five-cycle reply
        addr_bus = 16'h4C05; ram_read = 1'b1; ready_pulses = 0;
        tick();
        check("sd_rd_req", 32'({sd_read, sd_write}), 32'h2);
        check("sd_rd_busy", 32'(ram_busy), 32'h1);
        check("sd_rd_addr", 32'(sd_addr), 32'h000005);
        sd_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ram_ready) ready_pulses++;
            check("sd_rd_hold", 32'({sd_read, ram_busy}), 32'h3);
        end
        sd_ready = 1'b1; sd_rdata = 16'hBEEF; sd_busy = 1'b0;
        tick();
        sd_ready = 1'b0; ram_read = 1'b0;
        check("sd_rd_drop", 32'(sd_read), 32'h0);
        check("sd_rd_data", 32'(ram_out), 32'hBEEF);
        check("sd_rd_notbusy", 32'(ram_busy), 32'h0);
        if (ram_ready) ready_pulses++;
        tick();
        if (ram_ready) ready_pulses++;
        check("sd_rd_ready_out", 32'(ram_out), 32'hBEEF);
        show("sdram read");
        tick();
        if (ram_ready) ready_pulses++;
        check("sd_rd_single_ready", 32'(ready_pulses), 32'h1);

        // VGA read returns zero
        addr_bus = 16'h2000; ram_read = 1'b1;
        tick();
        ram_read = 1'b0;
        check("vga_rd_zero", 32'(ram_out), 32'h0);
        check("vga_rd_no_strobe", 32'(vga_write), 32'h0);
        tick();
        check("vga_rd_ready", 32'(ram_ready), 32'h1);
        tick();

        // Read and write together to SDRAM: write wins, immediate ready in SD_REQ
        addr_bus = 16'h5000; ram_in = 16'hCAFE; ram_read = 1'b1; ram_write = 1'b1;
        tick();
        check("sd_wr_req", 32'({sd_read, sd_write}), 32'h1);
        check("sd_wr_wdata", 32'(sd_wdata), 32'hCAFE);
        check("sd_wr_addr", 32'(sd_addr), 32'h000400);
        sd_ready = 1'b1; sd_rdata = 16'h1111;
        tick();
        sd_ready = 1'b0; ram_read = 1'b0; ram_write = 1'b0;
        check("sd_wr_drop", 32'({sd_read, sd_write}), 32'h0);
        tick();
        check("sd_wr_ready", 32'(ram_ready), 32'h1);
        show("sdram write");
        tick();

        // Unmapped read clears ram_out
        addr_bus = 16'h0FFF; ram_read = 1'b1;
        tick();
        ram_read = 1'b0;
        check("unmap_zero", 32'(ram_out), 32'h0);
        check("unmap_no_side", 32'({sd_read, sd_write, vga_write}), 32'h0);
        tick();
        check("unmap_ready", 32'(ram_ready), 32'h1);
        tick();

        // Reset during SD_WAIT
        addr_bus = 16'h4C00; ram_read = 1'b1;
        tick();
        sd_busy = 1'b1;
        tick();
        check("rstw_pre_read", 32'(sd_read), 32'h1);
        cpu_rst_n = 1'b0;
        tick();
        check("rstw_sd_read", 32'(sd_read), 32'h0);
        check("rstw_busy", 32'(ram_busy), 32'h0);
        show("reset in wait");
        cpu_rst_n = 1'b1; ram_read = 1'b0; sd_busy = 1'b0;
        tick();

        // Controller back in IDLE: short IO read completes in two edges
        addr_bus = 16'h0000; btn_in = 8'h3C; ram_read = 1'b1;
        tick();
        ram_read = 1'b0;
        check("post_rst_io_data", 32'(ram_out), 32'h003C);
        tick();
        check("post_rst_io_ready", 32'(ram_ready), 32'h1);
        tick();

`ifdef BUS_TIMEOUT_EN
        // SDRAM never answers
        addr_bus = 16'h4C01; ram_read = 1'b1; sd_busy = 1'b1; waited = 0;
        tick();
        waited = 1;
        while (!ram_ready && waited < 100) begin
            tick();
            waited++;
        end
        ram_read = 1'b0; sd_busy = 1'b0;
        check("tmo_latency", 32'(waited), 32'd66);
        check("tmo_data", 32'(ram_out), 32'hDEAD);
        check("tmo_bus_err", 32'(bus_err), 32'h1);
        check("tmo_sd_drop", 32'(sd_read), 32'h0);
        show("timeout");
        tick();
        check("tmo_err_sticky", 32'(bus_err), 32'h1);
`else
        waited = 0;
        check("bus_err_tied", 32'(bus_err), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
